// File: rtl/motor_reg_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : motor_reg_bank                                                |
// | Description : Byte-wide host register bank and address decoder for the     |
// |               drive and rotation motor controllers. Staged 12-bit targets   |
// |               committed atomically by CMD, sticky W1C fault status, and a   |
// |               registered read path with a one-cycle valid strobe.           |
// |               Optional interrupt block: define MOTOR_REG_BANK_IRQ_EN.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module motor_reg_bank #(
   parameter int NUM_DRIVE = 4,
   parameter int NUM_ROT   = 4,
   parameter int ADDR_W    = 6
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       address,
   input  logic                    write_en,
   input  logic [7:0]              wr_data,
   input  logic                    read_en,
   output logic [7:0]              rd_data,
   output logic                    rd_valid,
   input  logic [NUM_DRIVE-1:0]    fault_d,
   input  logic [7*NUM_DRIVE-1:0]  adc_temp_d,
   output logic [NUM_DRIVE-1:0]    brake_d,
   output logic [NUM_DRIVE-1:0]    enable_d,
   output logic [NUM_DRIVE-1:0]    direction_d,
   output logic [5*NUM_DRIVE-1:0]  pwm_d,
   input  logic [NUM_ROT-1:0]      fault_r,
   input  logic [NUM_ROT-1:0]      startup_fail_r,
   input  logic [NUM_ROT-1:0]      angle_done,
   input  logic [6*NUM_ROT-1:0]    adc_temp_r,
   input  logic [12*NUM_ROT-1:0]   current_angle,
   output logic [NUM_ROT-1:0]      brake_r,
   output logic [NUM_ROT-1:0]      enable_r,
   output logic [NUM_ROT-1:0]      direction_r,
   output logic [12*NUM_ROT-1:0]   target_angle,
   output logic [NUM_ROT-1:0]      update_angle,
   output logic [NUM_ROT-1:0]      abort_angle,
   output logic                    irq
);

   // Address map derived from the channel counts.
   localparam int DB = 4;
   localparam int RB = DB + 2*NUM_DRIVE;
   localparam int G  = RB + 4*NUM_ROT;

   localparam logic [ADDR_W-1:0] BCAST_ALL = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] BCAST_ROT = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] BCAST_DRV = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] G0_ADDR   = ADDR_W'(G);
   localparam logic [ADDR_W-1:0] G1_ADDR   = ADDR_W'(G + 1);

   logic [NUM_DRIVE-1:0]  drv_fault;
   logic [NUM_ROT-1:0]    rot_fault;
   logic [NUM_ROT-1:0]    rot_sfail;
   logic [12*NUM_ROT-1:0] rot_stage;
   logic [7:0]            w_rd_next;
   logic                  r_rd_valid;

   // Only channel 0 exposes its low angle byte; the rest of the bus is not read.
   logic unused_angle_bits;
   assign unused_angle_bits = ^current_angle;

   // ---------------------------------------------------------------- drive
   for (genvar i = 0; i < NUM_DRIVE; i++) begin : g_drive
      localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(DB + 2*i);
      localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(DB + 2*i + 1);

      logic       w_ctrl_we;
      logic       w_stat_we;
      logic       r_brake;
      logic       r_enable;
      logic       r_dir;
      logic [4:0] r_pwm;
      logic       r_fault;

      assign w_ctrl_we = write_en && ((address == CTRL_A) || (address == BCAST_ALL) ||
                                      (address == BCAST_DRV));
      assign w_stat_we = write_en && (address == STAT_A);

      // Control fields load on write; fault latches until W1C, a new fault wins.
      always_ff @(posedge clock) begin
         if (reset) begin
            r_brake  <= 1'b0;
            r_enable <= 1'b0;
            r_dir    <= 1'b0;
            r_pwm    <= 5'd0;
            r_fault  <= 1'b0;
         end else begin
            if (w_ctrl_we) begin
               r_brake  <= wr_data[7];
               r_enable <= wr_data[6];
               r_dir    <= wr_data[5];
               r_pwm    <= wr_data[4:0];
            end
            if (fault_d[i])
               r_fault <= 1'b1;
            else if (w_stat_we && wr_data[7])
               r_fault <= 1'b0;
         end
      end

      assign brake_d[i]         = r_brake;
      assign enable_d[i]        = r_enable;
      assign direction_d[i]     = r_dir;
      assign pwm_d[5*i +: 5]    = r_pwm;
      assign drv_fault[i]       = r_fault;
   end

   // ------------------------------------------------------------- rotation
   for (genvar k = 0; k < NUM_ROT; k++) begin : g_rot
      localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(RB + 4*k);
      localparam logic [ADDR_W-1:0] TLO_A  = ADDR_W'(RB + 4*k + 1);
      localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(RB + 4*k + 2);
      localparam logic [ADDR_W-1:0] CMD_A  = ADDR_W'(RB + 4*k + 3);

      logic        w_ctrl_we;
      logic        w_tlo_we;
      logic        w_stat_we;
      logic        w_cmd_we;
      logic        r_brake;
      logic        r_enable;
      logic        r_dir;
      logic [11:0] r_stage;
      logic [11:0] r_target;
      logic        r_upd;
      logic        r_abt;
      logic        r_fault;
      logic        r_sfail;

      assign w_ctrl_we = write_en && ((address == CTRL_A) || (address == BCAST_ALL) ||
                                      (address == BCAST_ROT));
      assign w_tlo_we  = write_en && (address == TLO_A);
      assign w_stat_we = write_en && (address == STAT_A);
      assign w_cmd_we  = write_en && (address == CMD_A);

      // Controls act at once; target bits go to staging and only reach the
      // controller on an update command. Abort beats update and rolls staging
      // back to the committed value.
      always_ff @(posedge clock) begin
         if (reset) begin
            r_brake  <= 1'b0;
            r_enable <= 1'b0;
            r_dir    <= 1'b0;
            r_stage  <= 12'd0;
            r_target <= 12'd0;
            r_upd    <= 1'b0;
            r_abt    <= 1'b0;
            r_fault  <= 1'b0;
            r_sfail  <= 1'b0;
         end else begin
            r_upd <= 1'b0;
            r_abt <= 1'b0;
            if (w_ctrl_we) begin
               r_brake        <= wr_data[7];
               r_enable       <= wr_data[6];
               r_dir          <= wr_data[5];
               r_stage[11:8]  <= wr_data[3:0];
            end
            if (w_tlo_we)
               r_stage[7:0] <= wr_data;
            if (w_cmd_we) begin
               if (wr_data[4]) begin
                  r_abt   <= 1'b1;
                  r_stage <= r_target;
               end else if (wr_data[5]) begin
                  r_upd    <= 1'b1;
                  r_target <= r_stage;
               end
            end
            if (fault_r[k])
               r_fault <= 1'b1;
            else if (w_stat_we && wr_data[7])
               r_fault <= 1'b0;
            if (startup_fail_r[k])
               r_sfail <= 1'b1;
            else if (w_stat_we && wr_data[6])
               r_sfail <= 1'b0;
         end
      end

      assign brake_r[k]              = r_brake;
      assign enable_r[k]             = r_enable;
      assign direction_r[k]          = r_dir;
      assign target_angle[12*k +: 12] = r_target;
      assign rot_stage[12*k +: 12]   = r_stage;
      assign rot_fault[k]            = r_fault;
      assign rot_sfail[k]            = r_sfail;
      // Reset masks a pulse already registered for this cycle.
      assign update_angle[k]         = r_upd & ~reset;
      assign abort_angle[k]          = r_abt & ~reset;
   end

   // ------------------------------------------------------------ interrupt
`ifdef MOTOR_REG_BANK_IRQ_EN
   logic [2:0]         r_irq_mask;
   logic [2:0]         r_irq_pend;
   logic [NUM_ROT-1:0] r_done_prev;
   logic               r_irq;
   logic [2:0]         w_pend_set;
   logic [2:0]         w_pend_clr;

   assign w_pend_set = {|(angle_done & ~r_done_prev), |(rot_fault | rot_sfail), |drv_fault};
   assign w_pend_clr = (write_en && (address == G1_ADDR)) ? wr_data[2:0] : 3'b000;

   // Pending bits are W1C with set priority; irq is the registered masked OR.
   // G+0 writes set the mask; G+0 reads keep returning the angle low byte.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_irq_mask  <= 3'b000;
         r_irq_pend  <= 3'b000;
         r_done_prev <= '0;
         r_irq       <= 1'b0;
      end else begin
         r_done_prev <= angle_done;
         if (write_en && (address == G0_ADDR))
            r_irq_mask <= wr_data[2:0];
         r_irq_pend <= w_pend_set | (r_irq_pend & ~w_pend_clr);
         r_irq      <= |(r_irq_pend & r_irq_mask);
      end
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   // ------------------------------------------------------------ read path
   // Combinational decode of the current (pre-write) register contents.
   always_comb begin
      w_rd_next = 8'h00;
      for (int i = 0; i < NUM_DRIVE; i++) begin
         if (address == ADDR_W'(DB + 2*i))
            w_rd_next = {brake_d[i], enable_d[i], direction_d[i], pwm_d[5*i +: 5]};
         if (address == ADDR_W'(DB + 2*i + 1))
            w_rd_next = {drv_fault[i], adc_temp_d[7*i +: 7]};
      end
      for (int k = 0; k < NUM_ROT; k++) begin
         if (address == ADDR_W'(RB + 4*k))
            w_rd_next = {brake_r[k], enable_r[k], direction_r[k], 1'b0, rot_stage[12*k+8 +: 4]};
         if (address == ADDR_W'(RB + 4*k + 1))
            w_rd_next = rot_stage[12*k +: 8];
         if (address == ADDR_W'(RB + 4*k + 2))
            w_rd_next = {rot_fault[k], rot_sfail[k], adc_temp_r[6*k +: 6]};
         if (address == ADDR_W'(RB + 4*k + 3))
            w_rd_next = {angle_done[k], 3'b000, current_angle[12*k+8 +: 4]};
      end
      if (address == G0_ADDR)
         w_rd_next = current_angle[7:0];
`ifdef MOTOR_REG_BANK_IRQ_EN
      if (address == G1_ADDR)
         w_rd_next = {5'b00000, r_irq_pend};
`endif
   end

   // Capture read data on read_en; data holds until the next read.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data    <= 8'h00;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= read_en;
         if (read_en)
            rd_data <= w_rd_next;
      end
   end

   assign rd_valid = r_rd_valid & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_motor_reg_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_motor_reg_bank                                             |
// | Description : Directed self-checking bench for motor_reg_bank (default      |
// |               4 drive / 4 rotation channels, 6-bit address).                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_motor_reg_bank;
   localparam int ND = 4;
   localparam int NR = 4;
   localparam int AW = 6;

   logic            clock = 1'b0;
   logic            reset;
   logic [AW-1:0]   address;
   logic            write_en;
   logic [7:0]      wr_data;
   logic            read_en;
   logic [7:0]      rd_data;
   logic            rd_valid;
   logic [ND-1:0]   fault_d;
   logic [7*ND-1:0] adc_temp_d;
   logic [ND-1:0]   brake_d, enable_d, direction_d;
   logic [5*ND-1:0] pwm_d;
   logic [NR-1:0]   fault_r, startup_fail_r, angle_done;
   logic [6*NR-1:0] adc_temp_r;
   logic [12*NR-1:0] current_angle;
   logic [NR-1:0]   brake_r, enable_r, direction_r;
   logic [12*NR-1:0] target_angle;
   logic [NR-1:0]   update_angle, abort_angle;
   logic            irq;

   int tests = 0;
   int fails = 0;

   motor_reg_bank #(.NUM_DRIVE(ND), .NUM_ROT(NR), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset), .address(address), .write_en(write_en),
      .wr_data(wr_data), .read_en(read_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .fault_d(fault_d), .adc_temp_d(adc_temp_d), .brake_d(brake_d),
      .enable_d(enable_d), .direction_d(direction_d), .pwm_d(pwm_d),
      .fault_r(fault_r), .startup_fail_r(startup_fail_r), .angle_done(angle_done),
      .adc_temp_r(adc_temp_r), .current_angle(current_angle), .brake_r(brake_r),
      .enable_r(enable_r), .direction_r(direction_r), .target_angle(target_angle),
      .update_angle(update_angle), .abort_angle(abort_angle), .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
      address  = a;
      wr_data  = d;
      write_en = 1'b1;
      tick();
      write_en = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [7:0] exp, input string tag);
      address = a;
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      check({tag, "_valid"}, rd_valid, 1'b1);
      check({tag, "_data"}, rd_data, exp);
      tick();
      check({tag, "_valid_drop"}, rd_valid, 1'b0);
      check({tag, "_hold"}, rd_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; address = '0; write_en = 1'b0; wr_data = '0; read_en = 1'b0;
      fault_d = '0; adc_temp_d = '0; fault_r = '0; startup_fail_r = '0;
      angle_done = '0; adc_temp_r = '0; current_angle = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // Reset state
      check("rst_brake_d", brake_d, 4'h0);
      check("rst_pwm_d", pwm_d, 20'h0);
      check("rst_brake_r", brake_r, 4'h0);
      check("rst_target", target_angle, 48'h0);
      check("rst_pulses", {update_angle, abort_angle}, 8'h00);
      check("rst_rd", {rd_valid, rd_data}, 9'h000);
      check("rst_irq", irq, 1'b0);

      // Global broadcast
      wr(6'h01, 8'hC5);
      check("bc_brake_d", brake_d, 4'hF);
      check("bc_enable_d", enable_d, 4'hF);
      check("bc_dir_d", direction_d, 4'h0);
      check("bc_pwm_d", pwm_d, {4{5'h05}});
      check("bc_brake_r", brake_r, 4'hF);
      rd(6'h04, 8'hC5, "bc_rd_drv0");
      rd(6'h0C, 8'hC5, "bc_rd_rot0");

      // Drive-only and rotation-only broadcasts
      wr(6'h03, 8'h3F);
      check("bd_brake_d", brake_d, 4'h0);
      check("bd_dir_d", direction_d, 4'hF);
      check("bd_pwm_d", pwm_d, {4{5'h1F}});
      check("bd_brake_r_kept", brake_r, 4'hF);
      wr(6'h02, 8'h20);
      check("br_brake_r", brake_r, 4'h0);
      check("br_dir_r", direction_r, 4'hF);
      check("br_dir_d_kept", direction_d, 4'hF);

      // Atomic target commit
      wr(6'h0C, 8'h0A);
      check("at_stage_hi", target_angle, 48'h0);
      wr(6'h0D, 8'hBC);
      check("at_stage_lo", target_angle, 48'h0);
      check("at_no_upd", update_angle, 4'h0);
      wr(6'h0F, 8'h20);
      check("at_target", target_angle, 48'h000_000_000_ABC);
      check("at_upd_pulse", update_angle, 4'h1);
      tick();
      check("at_upd_end", update_angle, 4'h0);
      check("at_target_hold", target_angle, 48'h000_000_000_ABC);

      // Back-to-back CMD writes
      address = 6'h0F; wr_data = 8'h20; write_en = 1'b1;
      tick();
      check("b2b_pulse1", update_angle, 4'h1);
      tick();
      write_en = 1'b0;
      check("b2b_pulse2", update_angle, 4'h1);
      tick();
      check("b2b_end", update_angle, 4'h0);

      // CMD readback and current-angle low byte
      current_angle = 48'h000_000_000_5A3;
      angle_done    = 4'b0001;
      rd(6'h0F, 8'h85, "cmd_rd");
      rd(6'h1C, 8'hA3, "ang_lo");
`ifdef MOTOR_REG_BANK_IRQ_EN
      rd(6'h1D, 8'h04, "pend_done");
      wr(6'h1C, 8'h04);
      tick();
      check("irq_set", irq, 1'b1);
      wr(6'h1D, 8'h04);
      check("irq_w1c_lag", irq, 1'b1);
      tick();
      check("irq_drop", irq, 1'b0);
      rd(6'h1D, 8'h00, "pend_cleared");
`else
      rd(6'h1D, 8'h00, "g1_off");
      wr(6'h1D, 8'h07);
      tick();
      check("irq_off", irq, 1'b0);
`endif

      // Abort priority from a fresh reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("ab_rst_target", target_angle, 48'h0);
      check("ab_rst_brake_d", brake_d, 4'h0);
      wr(6'h0C, 8'h01);
      wr(6'h0D, 8'h23);
      wr(6'h0F, 8'h30);
      check("ab_abort", abort_angle, 4'h1);
      check("ab_no_upd", update_angle, 4'h0);
      check("ab_target", target_angle, 48'h0);
      tick();
      check("ab_abort_end", abort_angle, 4'h0);
      rd(6'h0D, 8'h00, "ab_stage_lo");
      rd(6'h0C, 8'h00, "ab_stage_hi");

      // Read and write of the same address in one cycle returns old value
      address = 6'h0D; wr_data = 8'h55; write_en = 1'b1; read_en = 1'b1;
      tick();
      write_en = 1'b0; read_en = 1'b0;
      check("rw_old", rd_data, 8'h00);
      rd(6'h0D, 8'h55, "rw_new");

      // Drive sticky fault
      adc_temp_d = 28'h15 << 7;
      fault_d = 4'b0010;
      tick();
      fault_d = 4'b0000;
      rd(6'h07, 8'h95, "sf_set");
      rd(6'h05, 8'h00, "sf_other");
      fault_d = 4'b0010;
      wr(6'h07, 8'h80);
      fault_d = 4'b0000;
      rd(6'h07, 8'h95, "sf_set_wins");
      wr(6'h07, 8'h80);
      rd(6'h07, 8'h15, "sf_cleared");

      // Rotation sticky bits
      adc_temp_r = 24'h2A << 12;
      startup_fail_r = 4'b0100;
      tick();
      startup_fail_r = 4'b0000;
      rd(6'h16, 8'h6A, "rs_sfail");
      fault_r = 4'b0100;
      tick();
      fault_r = 4'b0000;
      rd(6'h16, 8'hEA, "rs_both");
      wr(6'h16, 8'h40);
      rd(6'h16, 8'hAA, "rs_clr_sfail");
      wr(6'h16, 8'h80);
      rd(6'h16, 8'h2A, "rs_clr_fault");

      // Reserved and unmapped addresses
      rd(6'h3F, 8'h00, "unmapped");
      rd(6'h00, 8'h00, "reserved");
      wr(6'h00, 8'hFF);
      check("res_wr_drv", {brake_d, enable_d, direction_d}, 12'h000);
      check("res_wr_rot", {brake_r, enable_r, direction_r}, 12'h000);

      // Reset in the cycle after a CMD write and read
      wr(6'h0C, 8'hC7);
      check("mr_pre_brake", brake_r, 4'h1);
      address = 6'h0F; wr_data = 8'h20; write_en = 1'b1; read_en = 1'b1;
      tick();
      write_en = 1'b0; read_en = 1'b0;
      reset = 1'b1;
      #1;
      check("mr_no_pulse", update_angle, 4'h0);
      check("mr_no_valid", rd_valid, 1'b0);
      tick();
      reset = 1'b0;
      check("mr_target", target_angle, 48'h0);
      check("mr_ctrl_r", {brake_r, enable_r, direction_r}, 12'h000);
      check("mr_pulses", {update_angle, abort_angle}, 8'h00);
      check("mr_rd", {rd_valid, rd_data}, 9'h000);
      check("mr_irq", irq, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
